// File: rtl/instruction_execute.sv
// Execute stage: ALU, multiply(-accumulate) and address generation, plus the
// cycle sequencing of write-back enables and the memory transaction type.
module instruction_execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_i,
  input  logic [3:0]  dest_i,
  input  logic        write_dest_do_i,
  input  logic        write_dest_m_i,
  input  logic        write_cpsr_i,
  input  logic [31:0] do_cycle_i,
  input  logic [31:0] m_ma_cycle_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [3:0]  opcode_i,
  input  logic [2:0]  type_i,
  input  logic [31:0] cpsr_i,
  output logic [3:0]  dest_o,
  output logic        write_dest_do_o,
  output logic        write_dest_m_o,
  output logic        write_cpsr_o,
  output logic        write_o,
  output logic [1:0]  trans_o,
  output logic [31:0] result_o,
  output logic [63:0] m_result_o
);

  function automatic logic [31:0] alu_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cf);
    logic [31:0] nc;
    nc = {31'd0, ~cf};
    case (op)
      4'h0:    alu_op = a & b;
      4'h1:    alu_op = a ^ b;
      4'h2:    alu_op = a - b;
      4'h3:    alu_op = b - a;
      4'h4:    alu_op = a + b;
      4'h5:    alu_op = a + b + {31'd0, cf};
      4'h6:    alu_op = a - b - nc;
      4'h7:    alu_op = b - a - nc;
      4'h8:    alu_op = a & b;
      4'h9:    alu_op = a ^ b;
      4'hA:    alu_op = a - b;
      4'hB:    alu_op = a + b;
      4'hC:    alu_op = a | b;
      4'hD:    alu_op = b;
      4'hE:    alu_op = a & ~b;
      4'hF:    alu_op = ~b;
      default: alu_op = 32'd0;
    endcase
  endfunction

  logic [31:0] cyc_r, cyc_s, last_s;
  logic [2:0]  type_r, type_s;
  logic        wdo_r, wdo_s, wm_r, wm_s, wc_r, wc_s;
  logic [31:0] do_cyc_r, do_cyc_s, m_cyc_r, m_cyc_s;
  logic [31:0] mul32_s, res_s;
  logic [63:0] umul_s, smul_s, mres_s;
  logic        nop_s, mem_s, do_hit_s, m_hit_s;

  // Datapath results for the instruction presented this cycle
  always_comb begin
    mul32_s = a_i * b_i + c_i;
    umul_s  = {32'd0, a_i} * {32'd0, b_i} + {d_i, c_i};
    smul_s  = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i} + {d_i, c_i};
    res_s   = 32'd0;
    mres_s  = 64'd0;
    case (type_i)
      3'd0, 3'd4, 3'd5: res_s = alu_op(opcode_i, a_i, b_i, cpsr_i[29]);
      3'd1: begin
        res_s  = mul32_s;
        mres_s = {32'd0, mul32_s};
      end
      3'd2: begin
        mres_s = umul_s;
        res_s  = umul_s[31:0];
      end
      3'd3: begin
        mres_s = smul_s;
        res_s  = smul_s[31:0];
      end
      default: begin
        res_s  = 32'd0;
        mres_s = 64'd0;
      end
    endcase
  end

  // Next cycle count and next latched instruction attributes
  always_comb begin
    last_s = 32'd1;
    if (do_cyc_r > last_s) last_s = do_cyc_r;
    else last_s = last_s;
    if (m_cyc_r > last_s) last_s = m_cyc_r;
    else last_s = last_s;

    if (exec_i) cyc_s = 32'd1;
    else if (cyc_r == 32'd0) cyc_s = 32'd0;
    else if (cyc_r == last_s) cyc_s = 32'd0;
    else cyc_s = cyc_r + 32'd1;

    if (exec_i) begin
      type_s   = type_i;
      wdo_s    = write_dest_do_i;
      wm_s     = write_dest_m_i;
      wc_s     = write_cpsr_i;
      do_cyc_s = do_cycle_i;
      m_cyc_s  = m_ma_cycle_i;
    end else begin
      type_s   = type_r;
      wdo_s    = wdo_r;
      wm_s     = wm_r;
      wc_s     = wc_r;
      do_cyc_s = do_cyc_r;
      m_cyc_s  = m_cyc_r;
    end

    nop_s    = (type_s[2:1] == 2'b11);
    mem_s    = (type_s == 3'd4) || (type_s == 3'd5);
    do_hit_s = (cyc_s != 32'd0) && (cyc_s == do_cyc_s) && !nop_s;
    m_hit_s  = (cyc_s != 32'd0) && (cyc_s == m_cyc_s) && !nop_s;
  end

  // State and registered outputs; pulses are computed from the next cycle count
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r           <= 32'd0;
      type_r          <= 3'd0;
      wdo_r           <= 1'b0;
      wm_r            <= 1'b0;
      wc_r            <= 1'b0;
      do_cyc_r        <= 32'd0;
      m_cyc_r         <= 32'd0;
      dest_o          <= 4'd0;
      result_o        <= 32'd0;
      m_result_o      <= 64'd0;
      write_dest_do_o <= 1'b0;
      write_dest_m_o  <= 1'b0;
      write_cpsr_o    <= 1'b0;
      write_o         <= 1'b0;
      trans_o         <= 2'b00;
    end else begin
      cyc_r           <= cyc_s;
      type_r          <= type_s;
      wdo_r           <= wdo_s;
      wm_r            <= wm_s;
      wc_r            <= wc_s;
      do_cyc_r        <= do_cyc_s;
      m_cyc_r         <= m_cyc_s;
      if (exec_i) begin
        dest_o     <= dest_i;
        result_o   <= res_s;
        m_result_o <= mres_s;
      end else begin
        dest_o     <= dest_o;
        result_o   <= result_o;
        m_result_o <= m_result_o;
      end
      write_dest_do_o <= do_hit_s && wdo_s;
      write_cpsr_o    <= do_hit_s && wc_s;
      write_dest_m_o  <= m_hit_s && wm_s;
      // Only loads/stores issue a data access; everything else is a fetch
      if (m_hit_s && mem_s) begin
        trans_o <= 2'b10;
        write_o <= (type_s == 3'd5);
      end else begin
        trans_o <= 2'b11;
        write_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_execute.sv
// Scoreboard bench for instruction_execute: stimulus pushes per-cycle expected
// records from a reference model; a negedge monitor pops and compares them.
module tb_instruction_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec_i = 1'b0;
  logic [3:0]  dest_i = 4'd0;
  logic        write_dest_do_i = 1'b0, write_dest_m_i = 1'b0, write_cpsr_i = 1'b0;
  logic [31:0] do_cycle_i = 32'd0, m_ma_cycle_i = 32'd0;
  logic [31:0] a_i = 32'd0, b_i = 32'd0, c_i = 32'd0, d_i = 32'd0, cpsr_i = 32'd0;
  logic [3:0]  opcode_i = 4'd0;
  logic [2:0]  type_i = 3'd0;
  logic [3:0]  dest_o;
  logic        write_dest_do_o, write_dest_m_o, write_cpsr_o, write_o;
  logic [1:0]  trans_o;
  logic [31:0] result_o;
  logic [63:0] m_result_o;

  instruction_execute dut (
    .clk(clk), .rst(rst), .exec_i(exec_i), .dest_i(dest_i),
    .write_dest_do_i(write_dest_do_i), .write_dest_m_i(write_dest_m_i),
    .write_cpsr_i(write_cpsr_i), .do_cycle_i(do_cycle_i), .m_ma_cycle_i(m_ma_cycle_i),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i), .opcode_i(opcode_i), .type_i(type_i),
    .cpsr_i(cpsr_i), .dest_o(dest_o), .write_dest_do_o(write_dest_do_o),
    .write_dest_m_o(write_dest_m_o), .write_cpsr_o(write_cpsr_o), .write_o(write_o),
    .trans_o(trans_o), .result_o(result_o), .m_result_o(m_result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic        do_p, m_p, c_p, wr;
    logic [1:0]  trans;
    logic [3:0]  dest;
    logic [31:0] res;
    logic [63:0] mres;
    bit          cr, cm;
  } ev_t;

  ev_t q[$];
  int  edge_count = 0;
  bit  rst_seen = 1'b0;
  bit  started = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) begin
    edge_count = edge_count + 1;
    rst_seen = rst;
    started = 1'b1;
  end

  // Monitor: reset state, scheduled active cycles, or quiet idle cycles
  ev_t e;
  always @(negedge clk) begin
    if (started) begin
      bit ok;
      if (rst_seen) begin
        ok = !write_dest_do_o && !write_dest_m_o && !write_cpsr_o && !write_o &&
             trans_o == 2'b00 && dest_o == 4'd0 && result_o == 32'd0 && m_result_o == 64'd0;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL reset t=%0d got do=%b m=%b c=%b tr=%b w=%b dest=%h res=%h mres=%h required all zero",
                   edge_count, write_dest_do_o, write_dest_m_o, write_cpsr_o, trans_o, write_o,
                   dest_o, result_o, m_result_o);
        end
      end else if (q.size() > 0 && q[0].t == edge_count) begin
        e = q.pop_front();
        ok = write_dest_do_o === e.do_p && write_dest_m_o === e.m_p && write_cpsr_o === e.c_p &&
             trans_o === e.trans && write_o === e.wr && dest_o === e.dest &&
             (!e.cr || result_o === e.res) && (!e.cm || m_result_o === e.mres);
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL active t=%0d got do=%b m=%b c=%b tr=%b w=%b dest=%h res=%h mres=%h required do=%b m=%b c=%b tr=%b w=%b dest=%h res=%h(%0d) mres=%h(%0d)",
                   edge_count, write_dest_do_o, write_dest_m_o, write_cpsr_o, trans_o, write_o,
                   dest_o, result_o, m_result_o, e.do_p, e.m_p, e.c_p, e.trans, e.wr, e.dest,
                   e.res, e.cr, e.mres, e.cm);
        end
      end else begin
        ok = write_dest_do_o === 1'b0 && write_dest_m_o === 1'b0 && write_cpsr_o === 1'b0 &&
             trans_o === 2'b11 && write_o === 1'b0;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL idle t=%0d got do=%b m=%b c=%b tr=%b w=%b required 0 0 0 11 0",
                   edge_count, write_dest_do_o, write_dest_m_o, write_cpsr_o, trans_o, write_o);
        end
      end
    end
  end

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, b, input int cf);
    case (op)
      0, 8:    return a & b;
      1, 9:    return a ^ b;
      2, 10:   return a - b;
      3:       return b - a;
      4, 11:   return a + b;
      5:       return a + b + cf;
      6:       return a - b - (1 - cf);
      7:       return b - a - (1 - cf);
      12:      return a | b;
      13:      return b;
      14:      return a & ~b;
      default: return ~b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  // Drive one instruction (called 1 time unit after a posedge) and schedule its outputs
  task automatic issue(input int op, input int ty, input logic [31:0] a, b, c, d, cpsr,
                       input int dest, input bit wdo, input bit wm, input bit wc,
                       input int dc, input int mc);
    int cur, cap, last;
    logic [31:0] r32;
    logic [63:0] r64;
    longint sa, sb;
    ev_t ev;
    cur = edge_count;
    cap = cur + 1;
    while (q.size() > 0 && q[$].t > cur) void'(q.pop_back());
    r32 = 32'd0;
    r64 = 64'd0;
    if (ty == 0 || ty == 4 || ty == 5) r32 = ref_alu(op, a, b, int'(cpsr[29]));
    else if (ty == 1) begin r32 = a * b + c; r64 = {32'd0, r32}; end
    else if (ty == 2) r64 = {32'd0, a} * {32'd0, b} + {d, c};
    else if (ty == 3) begin
      sa = $signed(a);
      sb = $signed(b);
      r64 = sa * sb + {d, c};
    end
    last = (dc > mc) ? dc : mc;
    if (last < 1) last = 1;
    for (int k = 1; k <= last; k++) begin
      ev.t     = cap + k - 1;
      ev.do_p  = (ty < 6) && wdo && (k == dc);
      ev.c_p   = (ty < 6) && wc && (k == dc);
      ev.m_p   = (ty < 6) && wm && (k == mc);
      ev.trans = ((ty == 4 || ty == 5) && k == mc) ? 2'b10 : 2'b11;
      ev.wr    = (ty == 5) && (k == mc);
      ev.dest  = dest[3:0];
      ev.res   = r32;
      ev.mres  = r64;
      ev.cr    = (ty != 2) && (ty != 3);
      ev.cm    = (ty >= 1);
      q.push_back(ev);
    end
    opcode_i = op[3:0]; type_i = ty[2:0]; a_i = a; b_i = b; c_i = c; d_i = d;
    cpsr_i = cpsr; dest_i = dest[3:0]; write_dest_do_i = wdo; write_dest_m_i = wm;
    write_cpsr_i = wc; do_cycle_i = dc; m_ma_cycle_i = mc; exec_i = 1'b1;
    @(posedge clk); #1;
    exec_i = 1'b0;
    a_i = $urandom; b_i = $urandom; opcode_i = 4'($urandom);
  endtask

  task automatic do_reset();
    int cur;
    cur = edge_count;
    while (q.size() > 0 && q[$].t > cur) void'(q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    issue(4, 0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 3, 1, 0, 0, 1, 0);
    @(negedge clk);
    chk("add_result", result_o, 64'd12);
    chk("add_pulse", write_dest_do_o, 64'd1);
    chk("add_dest", dest_o, 64'd3);
    @(negedge clk);
    chk("add_pulse_end", write_dest_do_o, 64'd0);
    @(posedge clk); #1;

    issue(5, 0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'h2000_0000, 1, 1, 0, 1, 1, 0);
    @(negedge clk); chk("adc_result", result_o, 64'd0);
    @(posedge clk); #1;
    issue(6, 0, 32'd10, 32'd3, 32'd0, 32'd0, 32'd0, 2, 1, 0, 0, 1, 0);
    @(negedge clk); chk("sbc_result", result_o, 64'd6);
    @(posedge clk); #1;
    issue(15, 0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 4, 1, 0, 0, 1, 0);
    @(negedge clk); chk("mvn_result", result_o, 64'hFFFFFFFF);
    @(posedge clk); #1;

    issue(0, 2, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd0, 32'd0, 5, 0, 1, 0, 0, 2);
    @(negedge clk);
    chk("umlal_result", m_result_o, 64'h1_FFFFFFFF);
    chk("umlal_m_c1", write_dest_m_o, 64'd0);
    @(negedge clk); chk("umlal_m_c2", write_dest_m_o, 64'd1);
    @(posedge clk); #1;
    issue(0, 3, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'd0, 6, 0, 1, 0, 0, 1);
    @(negedge clk); chk("smull_result", m_result_o, 64'hFFFFFFFF_FFFFFFFA);
    @(posedge clk); #1;

    issue(4, 5, 32'h100, 32'd4, 32'd0, 32'd0, 32'd0, 7, 0, 0, 0, 0, 2);
    @(negedge clk);
    chk("store_addr", result_o, 64'h104);
    chk("store_c1", {write_o, trans_o}, 64'b011);
    @(negedge clk); chk("store_c2", {write_o, trans_o}, 64'b110);
    @(negedge clk); chk("store_c3", {write_o, trans_o}, 64'b011);
    @(posedge clk); #1;

    issue(4, 0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 8, 1, 0, 1, 2, 0);
    do_reset();
    @(negedge clk);
    chk("abort_pulse", write_dest_do_o, 64'd0);
    chk("abort_result", result_o, 64'd0);
    @(posedge clk); #1;
    idle(3);

    for (int n = 0; n < 300; n++) begin
      int ty, op;
      ty = $urandom_range(0, 7);
      op = $urandom_range(0, 15);
      if (ty == 4 || ty == 5) op = ($urandom_range(0, 1) == 1) ? 4 : 2;
      if ($urandom_range(0, 39) == 0) do_reset();
      issue(op, ty, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4), $urandom_range(0, 4));
      idle($urandom_range(0, 4));
    end

    idle(8);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
